// File: rtl/aes128_round_ctrl_if.sv
// Host and datapath signal bundle for the AES-128 round controller.
// The master side is the host plus the external combinational round datapath.
interface aes128_round_ctrl_if;
    logic         start;
    logic         dec;
    logic [127:0] key;
    logic [127:0] din;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] dout;
    logic         dp_ark;
    logic         dp_ss;
    logic         dp_ssm;
    logic         dp_inv;
    logic [31:0]  dp_a;
    logic [127:0] dp_va;
    logic [127:0] dp_vb;
    logic [127:0] dp_vc;

    modport master (
        output start, dec, key, din, dp_vc,
        input  busy, done, err, dout,
        input  dp_ark, dp_ss, dp_ssm, dp_inv, dp_a, dp_va, dp_vb
    );

    modport slave (
        input  start, dec, key, din, dp_vc,
        output busy, done, err, dout,
        output dp_ark, dp_ss, dp_ssm, dp_inv, dp_a, dp_va, dp_vb
    );
endinterface

// File: rtl/aes128_round_ctrl.sv
// AES-128 round sequencer driving an external combinational round datapath.
// Decryption (key buffer, KXOR/DRND/DLAST) is built only with AES_ROUND_CTRL_DEC_EN.
module aes128_round_ctrl (
    input  logic              clk,
    input  logic              rst,
    aes128_round_ctrl_if.slave bus
);

`ifdef AES_ROUND_CTRL_DEC_EN
    typedef enum logic [2:0] {IDLE, EXP, RND, LAST, KXOR, DRND, DLAST} state_t;
`else
    typedef enum logic [2:0] {IDLE, EXP, RND, LAST} state_t;
`endif

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       fsm_q, fsm_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         dp_ark, dp_ss, dp_ssm;
    logic [31:0]  dp_a;
    logic [127:0] dp_va, dp_vb;

`ifdef AES_ROUND_CTRL_DEC_EN
    logic         dp_inv;
    logic         dec_q, dec_d;
    logic [127:0] kbuf_q [0:10];
    logic [127:0] kbuf_d [0:10];
`endif

    always_comb begin
        fsm_d   = fsm_q;
        rk_d    = rk_q;
        st_d    = st_q;
        dout_d  = dout_q;
        round_d = round_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dp_ark  = 1'b0;
        dp_ss   = 1'b0;
        dp_ssm  = 1'b0;
        dp_a    = 32'h0;
        dp_va   = 128'h0;
        dp_vb   = 128'h0;
`ifdef AES_ROUND_CTRL_DEC_EN
        dp_inv  = 1'b0;
        dec_d   = dec_q;
        kbuf_d  = kbuf_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
`ifndef AES_ROUND_CTRL_DEC_EN
                    if (bus.dec) err_d = 1'b1;
                    else
`endif
                    begin
                        fsm_d   = EXP;
                        rk_d    = bus.key;
                        round_d = 4'd1;
`ifdef AES_ROUND_CTRL_DEC_EN
                        dec_d     = bus.dec;
                        kbuf_d[0] = bus.key;
                        st_d      = bus.dec ? bus.din : (bus.din ^ bus.key);
`else
                        st_d      = bus.din ^ bus.key;
`endif
                    end
                end
            end
            EXP: begin
                dp_ark = 1'b1;
                dp_vb  = rk_q;
                dp_a   = {24'h0, rcon(round_q)};
                rk_d   = bus.dp_vc;
`ifdef AES_ROUND_CTRL_DEC_EN
                // Decrypt expands the full schedule up front, then walks it backwards.
                if (dec_q) begin
                    kbuf_d[round_q] = bus.dp_vc;
                    round_d         = round_q + 4'd1;
                    fsm_d           = (round_q == 4'd10) ? KXOR : EXP;
                end else
`endif
                fsm_d = (round_q == 4'd10) ? LAST : RND;
            end
            RND: begin
                dp_ssm  = 1'b1;
                dp_va   = rk_q;
                dp_vb   = st_q;
                st_d    = bus.dp_vc;
                round_d = round_q + 4'd1;
                fsm_d   = EXP;
            end
            LAST: begin
                dp_ss  = 1'b1;
                dp_va  = rk_q;
                dp_vb  = st_q;
                dout_d = bus.dp_vc;
                done_d = 1'b1;
                fsm_d  = IDLE;
            end
`ifdef AES_ROUND_CTRL_DEC_EN
            KXOR: begin
                // The whitening XOR is done locally; the select keeps the one-hot rule.
                dp_ark  = 1'b1;
                dp_va   = kbuf_q[10];
                dp_vb   = st_q;
                st_d    = st_q ^ kbuf_q[10];
                round_d = 4'd9;
                fsm_d   = DRND;
            end
            DRND: begin
                dp_ssm  = 1'b1;
                dp_inv  = 1'b1;
                dp_va   = kbuf_q[round_q];
                dp_vb   = st_q;
                st_d    = bus.dp_vc;
                round_d = round_q - 4'd1;
                fsm_d   = (round_q == 4'd1) ? DLAST : DRND;
            end
            DLAST: begin
                dp_ss  = 1'b1;
                dp_inv = 1'b1;
                dp_va  = kbuf_q[0];
                dp_vb  = st_q;
                dout_d = bus.dp_vc;
                done_d = 1'b1;
                fsm_d  = IDLE;
            end
`endif
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rk_q    <= '0;
            st_q    <= '0;
            dout_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef AES_ROUND_CTRL_DEC_EN
            dec_q   <= 1'b0;
            for (int i = 0; i < 11; i++) kbuf_q[i] <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            dout_q  <= dout_d;
            round_q <= round_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef AES_ROUND_CTRL_DEC_EN
            dec_q   <= dec_d;
            kbuf_q  <= kbuf_d;
`endif
        end
    end

    assign bus.busy   = (fsm_q != IDLE);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.dout   = dout_q;
    assign bus.dp_ark = dp_ark;
    assign bus.dp_ss  = dp_ss;
    assign bus.dp_ssm = dp_ssm;
    assign bus.dp_a   = dp_a;
    assign bus.dp_va  = dp_va;
    assign bus.dp_vb  = dp_vb;
`ifdef AES_ROUND_CTRL_DEC_EN
    assign bus.dp_inv = dp_inv;
`else
    assign bus.dp_inv = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl with a behavioural AES round datapath model.
module tb_aes128_round_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] c1_key, c1_pt, c1_ct, b_key, b_pt, b_ct, b_rk1;

    aes128_round_ctrl_if bus();

    aes128_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] v, r, s;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, v);
            s = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
            sbox[i]  = s;
            isbox[s] = v;
        end
    endtask

    function automatic logic [127:0] byte_rev(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = inv ? isbox[x[8*i +: 8]] : sbox[x[8*i +: 8]];
        return y;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                y[8*(r + 4*c) +: 8] = x[8*(r + 4*src) +: 8];
            end
        return y;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[32*c +: 8]; a1 = x[32*c+8 +: 8]; a2 = x[32*c+16 +: 8]; a3 = x[32*c+24 +: 8];
            if (!inv) begin
                y[32*c    +: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                y[32*c+8  +: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                y[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                y[32*c+24 +: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
            end else begin
                y[32*c    +: 8] = gmul(a0,14) ^ gmul(a1,11) ^ gmul(a2,13) ^ gmul(a3,9);
                y[32*c+8  +: 8] = gmul(a0,9) ^ gmul(a1,14) ^ gmul(a2,11) ^ gmul(a3,13);
                y[32*c+16 +: 8] = gmul(a0,13) ^ gmul(a1,9) ^ gmul(a2,14) ^ gmul(a3,11);
                y[32*c+24 +: 8] = gmul(a0,11) ^ gmul(a1,13) ^ gmul(a2,9) ^ gmul(a3,14);
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [127:0] y;
        for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox[k[96 + 8*((i + 1) % 4) +: 8]];
        t[7:0] = t[7:0] ^ rc;
        y[31:0]   = k[31:0]   ^ t;
        y[63:32]  = k[63:32]  ^ y[31:0];
        y[95:64]  = k[95:64]  ^ y[63:32];
        y[127:96] = k[127:96] ^ y[95:64];
        return y;
    endfunction

    function automatic logic [127:0] dp_model();
        logic [127:0] t;
        if (bus.dp_ark) return key_exp(bus.dp_vb, bus.dp_a[7:0]);
        if (!(bus.dp_ss || bus.dp_ssm)) return 128'h0;
        if (!bus.dp_inv) begin
            t = shift_rows(sub_bytes(bus.dp_vb, 1'b0), 1'b0);
            if (bus.dp_ssm) t = mix_cols(t, 1'b0);
            return t ^ bus.dp_va;
        end
        t = sub_bytes(shift_rows(bus.dp_vb, 1'b1), 1'b1) ^ bus.dp_va;
        if (bus.dp_ssm) t = mix_cols(t, 1'b1);
        return t;
    endfunction

    // Datapath selects settle after the rising edge; the result is ready well before the next one.
    always @(negedge clk) bus.dp_vc = dp_model();

    task automatic start_op(input logic d, input logic [127:0] k, input logic [127:0] x);
        bus.start = 1'b1; bus.dec = d; bus.key = k; bus.din = x;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output int busy_cnt, output int hot_bad);
        cyc = 0; busy_cnt = 0; hot_bad = 0;
        for (int i = 1; i <= limit; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && $countones({bus.dp_ark, bus.dp_ss, bus.dp_ssm}) != 1) hot_bad++;
            if (bus.done) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.dec = 1'b0; bus.key = c1_key; bus.din = c1_pt;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl busy/done/err got %b expected 000", {bus.busy, bus.done, bus.err});
        end
        n_tests++;
        if (bus.dout !== 128'h0) begin
            n_fail++; $display("FAIL reset_dout got %h expected 0", bus.dout);
        end
        n_tests++;
        if ({bus.dp_ark, bus.dp_ss, bus.dp_ssm, bus.dp_inv, bus.dp_a, bus.dp_va, bus.dp_vb} !== '0) begin
            n_fail++; $display("FAIL reset_dp got ark=%b ss=%b ssm=%b inv=%b a=%h expected all 0",
                               bus.dp_ark, bus.dp_ss, bus.dp_ssm, bus.dp_inv, bus.dp_a);
        end
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_ignored busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_enc_c1();
        int cyc, bc, hb;
        start_op(1'b0, c1_key, c1_pt);
        wait_done(30, cyc, bc, hb);
        n_tests++;
        if (cyc != 21) begin
            n_fail++; $display("FAIL enc_c1_latency got %0d expected 21", cyc);
        end
        n_tests++;
        if (bc != 20) begin
            n_fail++; $display("FAIL enc_c1_busy_cycles got %0d expected 20", bc);
        end
        n_tests++;
        if (hb != 0) begin
            n_fail++; $display("FAIL enc_c1_onehot bad cycles got %0d expected 0", hb);
        end
        n_tests++;
        if (bus.dout !== c1_ct || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL enc_c1_dout got %h busy=%b expected %h busy=0", bus.dout, bus.busy, c1_ct);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL enc_c1_done_pulse got %b expected 0", bus.done);
        end
    endtask

    task automatic test_enc_appb();
        int done_c;
        done_c = 0;
        start_op(1'b0, b_key, b_pt);
        for (int i = 1; i <= 25; i++) begin
            if (i == 1) begin
                n_tests++;
                if (bus.dp_ark !== 1'b1 || bus.dp_a !== 32'h1 || bus.dp_vb !== b_key) begin
                    n_fail++; $display("FAIL appb_exp1 got ark=%b a=%h vb=%h expected ark=1 a=1 vb=%h",
                                       bus.dp_ark, bus.dp_a, bus.dp_vb, b_key);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (bus.dp_ssm !== 1'b1 || bus.dp_va !== b_rk1) begin
                    n_fail++; $display("FAIL appb_rk1 got ssm=%b va=%h expected ssm=1 va=%h", bus.dp_ssm, bus.dp_va, b_rk1);
                end
            end
            if (i == 19) begin
                n_tests++;
                if (bus.dp_ark !== 1'b1 || bus.dp_a !== 32'h36) begin
                    n_fail++; $display("FAIL appb_rcon10 got ark=%b a=%h expected ark=1 a=36", bus.dp_ark, bus.dp_a);
                end
            end
            if (bus.done) begin
                done_c = i;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (done_c != 21 || bus.dout !== b_ct) begin
            n_fail++; $display("FAIL appb_result got cyc=%0d dout=%h expected cyc=21 dout=%h", done_c, bus.dout, b_ct);
        end
    endtask

    task automatic test_back_to_back();
        int done_c, cyc, bc, hb;
        done_c = 0;
        @(negedge clk);
        start_op(1'b0, c1_key, c1_pt);
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                bus.start = 1'b1; bus.key = b_key; bus.din = b_pt;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done) begin
                done_c = i;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (done_c != 21 || bus.dout !== c1_ct) begin
            n_fail++; $display("FAIL busy_start_ignored got cyc=%0d dout=%h expected cyc=21 dout=%h", done_c, bus.dout, c1_ct);
        end
        start_op(1'b0, b_key, b_pt);
        wait_done(30, cyc, bc, hb);
        n_tests++;
        if (cyc != 21 || bus.dout !== b_ct) begin
            n_fail++; $display("FAIL back_to_back got cyc=%0d dout=%h expected cyc=21 dout=%h", cyc, bus.dout, b_ct);
        end
    endtask

    task automatic test_reset_mid();
        int dones, cyc, bc, hb;
        dones = 0;
        @(negedge clk);
        start_op(1'b0, c1_key, c1_pt);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.dout !== 128'h0 ||
            {bus.dp_ark, bus.dp_ss, bus.dp_ssm, bus.dp_inv, bus.dp_a, bus.dp_va, bus.dp_vb} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs got busy=%b done=%b dout=%h expected all 0", bus.busy, bus.done, bus.dout);
        end
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++; $display("FAIL reset_mid_no_done got %0d done pulses expected 0", dones);
        end
        start_op(1'b0, b_key, b_pt);
        wait_done(30, cyc, bc, hb);
        n_tests++;
        if (cyc != 21 || bus.dout !== b_ct) begin
            n_fail++; $display("FAIL reset_mid_restart got cyc=%0d dout=%h expected cyc=21 dout=%h", cyc, bus.dout, b_ct);
        end
    endtask

`ifdef AES_ROUND_CTRL_DEC_EN
    task automatic test_dec();
        int cyc, bc, hb;
        @(negedge clk);
        start_op(1'b1, c1_key, c1_ct);
        wait_done(30, cyc, bc, hb);
        n_tests++;
        if (cyc != 22 || bc != 21 || hb != 0) begin
            n_fail++; $display("FAIL dec_timing got cyc=%0d busy=%0d onehot_bad=%0d expected 22 21 0", cyc, bc, hb);
        end
        n_tests++;
        if (bus.dout !== c1_pt) begin
            n_fail++; $display("FAIL dec_dout got %h expected %h", bus.dout, c1_pt);
        end
    endtask
`else
    task automatic test_dec();
        @(negedge clk);
        start_op(1'b1, c1_key, c1_ct);
        n_tests++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.dout !== b_ct) begin
            n_fail++; $display("FAIL dec_reject got err=%b busy=%b dout=%h expected err=1 busy=0 dout=%h",
                               bus.err, bus.busy, bus.dout, b_ct);
        end
        bus.dec = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL dec_reject_pulse got err=%b busy=%b expected err=0 busy=0", bus.err, bus.busy);
        end
    endtask
`endif

    initial begin
        init_sbox();
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; bus.start = 1'b0; bus.dec = 1'b0; bus.key = '0; bus.din = '0;
        c1_key = byte_rev(128'h000102030405060708090a0b0c0d0e0f);
        c1_pt  = byte_rev(128'h00112233445566778899aabbccddeeff);
        c1_ct  = byte_rev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        b_key  = byte_rev(128'h2b7e151628aed2a6abf7158809cf4f3c);
        b_pt   = byte_rev(128'h3243f6a8885a308d313198a2e0370734);
        b_ct   = byte_rev(128'h3925841d02dc09fbdc118597196a0b32);
        b_rk1  = byte_rev(128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk);
        test_reset();
        test_enc_c1();
        test_enc_appb();
        test_back_to_back();
        test_reset_mid();
        test_dec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have the following host-side ports, one per line:
- start  in  1  request pulse
- dec  in  1  1 = decrypt, 0 = encrypt, sampled with start
- key  in  128  cipher key
- din  in  128  input block
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle reject pulse
- dout  out  128  result block, held until the next accepted start
REQ-003 SHALL have the following datapath-side ports, one per line, feeding the combinational AES round datapath:
- dp_ark, dp_ss, dp_ssm, dp_inv  out  1 each  operation select
- dp_a  out  32  round constant
- dp_va  out  128  round key
- dp_vb  out  128  state or previous key
- dp_vc  in  128  datapath result
REQ-004 SHALL use byte order FIPS byte 0 at bits [7:0] and byte 15 at bits [127:120] on all 128-bit ports.

Function
REQ-005 SHALL implement the FSM states IDLE, EXP, RND, LAST, KXOR, DRND, DLAST.
REQ-006 SHALL, in IDLE, accept start only when busy=0; start while busy=1 SHALL be ignored without side effect.
REQ-007 SHALL, on the accept edge, register key into rk and set round=1.
- Encrypt: state<=din^key.
- Decrypt: state<=din.
REQ-008 SHALL drive exactly one of dp_ark/dp_ss/dp_ssm high per busy cycle.
- dp_ark in EXP; dp_ss in LAST/DLAST; dp_ssm in RND/DRND.
- All dp_* outputs SHALL be 0 in IDLE.
REQ-009 EXP (key expansion) SHALL drive:
- dp_vb=rk, dp_inv=0, dp_a={24'h0,rcon(round)}, with rcon sequence 01,02,04,08,10,20,40,80,1b,36.
- The cycle SHALL register rk<=dp_vc.
REQ-010 Encrypt SHALL alternate EXP and RND/LAST:
- RND/LAST drive dp_vb=state, dp_va=rk, dp_inv=0; state<=dp_vc; round increments after RND.
- Rounds 1-9 use RND; round 10 uses LAST.
- Encrypt occupies 20 busy cycles.
REQ-011 Decrypt SHALL run 10 consecutive EXP cycles, storing rk0..rk10 in an 11-entry key buffer.
- KXOR: state<=state^rk10.
- DRND for r=9..1: dp_inv=1, dp_va=rk[r], dp_vb=state.
- DLAST: dp_inv=1, dp_va=rk0.
- Decrypt occupies 21 busy cycles.
REQ-012 SHALL register dout<=dp_vc on the LAST/DLAST edge, then return to IDLE.
- done=1 and busy=0 in the following cycle.
- A start in that same cycle SHALL be accepted.
REQ-013 busy SHALL be 1 from the cycle after the accept edge through the LAST/DLAST cycle inclusive.
REQ-014 Latency SHALL be done asserted 21 cycles (encrypt) or 22 cycles (decrypt) after the accept edge.
REQ-015 key/din changes while busy SHALL NOT affect the operation in progress.

Reset
REQ-016 rst=1 SHALL, on the next clk edge, force IDLE and clear all outputs to 0.
- Covers busy, done, err, dout, dp_*.
- Covers rk, state, round and the key buffer.
REQ-017 Reset mid-operation SHALL abort with no done pulse; start sampled while rst=1 SHALL be ignored.

Configuration
REQ-018 Macro AES_ROUND_CTRL_DEC_EN SHALL gate decryption support:
- Defined: the key buffer, KXOR/DRND/DLAST and dp_inv=1 are implemented.
- Undefined: the key buffer and decrypt states are absent, and dp_inv is tied 0.
- Undefined: start with dec=1 SHALL NOT be accepted; it produces err=1 for one cycle the next cycle, with busy staying 0 and dout unchanged.

Verification
REQ-019 Encrypt, key=0x0f0e..0100, din=0xffee..1100 (FIPS C.1, byte-reversed) -> done at +21 cycles, dout = byte-reversed 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-020 Encrypt, FIPS Appendix B key 2b7e1516.. and pt 3243f6a8.. (byte-reversed) -> dout = byte-reversed 3925841d02dc09fbdc118597196a0b32; rk after the first EXP = byte-reversed a0fafe1788542cb123a339392a6c7605.
REQ-021 Decrypt (macro defined), C.1 ciphertext -> done at +22 cycles, dout = C.1 plaintext; rerun with macro undefined -> err pulse, busy stays 0.
REQ-022 start pulsed at cycle +5 of a busy encrypt with different key/din -> ignored; first result correct; a start in the done cycle is accepted back-to-back.
REQ-023 rst asserted at cycle +10 of encrypt -> all outputs 0 next cycle, no done; a subsequent start completes correctly.
